// File: rtl/apb_to_obi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_to_obi_bridge_pkg
// Shared types for the APB completer -> OBI manager bridge.
//   bridge_state_e : bridge FSM states
//   bridge_req_t   : request captured from the APB setup phase
// ----------------------------------------------------------------------------
package apb_to_obi_bridge_pkg;

    localparam int unsigned BRIDGE_AW = 32;
    localparam int unsigned BRIDGE_DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        DONE,
        DRAIN_REQ,
        DRAIN_RSP
    } bridge_state_e;

    typedef struct packed {
        logic [BRIDGE_AW-1:0]   addr;
        logic                   we;
        logic [BRIDGE_DW/8-1:0] be;
        logic [BRIDGE_DW-1:0]   wdata;
    } bridge_req_t;

endpackage

// File: rtl/apb_to_obi_bridge.sv
// ----------------------------------------------------------------------------
// apb_to_obi_bridge
// APB completer that forwards each APB transfer as a single OBI transaction.
// One transfer outstanding; a timeout forces an APB error if the OBI side
// stalls, and any late OBI grant/response is drained before the next transfer.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   APB_P*                             APB completer interface
//   obi_req/gnt/addr/we/be/wdata/aid   OBI A channel (manager side)
//   obi_rvalid/rready/rdata/err/rid    OBI R channel
// All outputs are driven straight from registers.
// ----------------------------------------------------------------------------
module apb_to_obi_bridge
    import apb_to_obi_bridge_pkg::*;
#(
    parameter int unsigned        APB_AW         = BRIDGE_AW,
    parameter int unsigned        APB_DW         = BRIDGE_DW,
    parameter int unsigned        OBI_IDW        = 1,
    parameter logic [OBI_IDW-1:0] OBI_ID         = '0,
    parameter int unsigned        TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [APB_AW-1:0]   APB_PADDR,
    input  logic                APB_PSEL,
    input  logic                APB_PENABLE,
    input  logic                APB_PWRITE,
    input  logic [APB_DW-1:0]   APB_PWDATA,
    input  logic [APB_DW/8-1:0] APB_PSTRB,
    output logic [APB_DW-1:0]   APB_PRDATA,
    output logic                APB_PREADY,
    output logic                APB_PSLVERR,
    output logic                obi_req,
    input  logic                obi_gnt,
    output logic [APB_AW-1:0]   obi_addr,
    output logic                obi_we,
    output logic [APB_DW/8-1:0] obi_be,
    output logic [APB_DW-1:0]   obi_wdata,
    output logic [OBI_IDW-1:0]  obi_aid,
    input  logic                obi_rvalid,
    output logic                obi_rready,
    input  logic [APB_DW-1:0]   obi_rdata,
    input  logic                obi_err,
    input  logic [OBI_IDW-1:0]  obi_rid
);

    // Counter is kept 1 bit wide when the timeout is disabled so it never
    // collapses to zero width; w_timeout is then forced low.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    bridge_state_e       r_state;
    bridge_state_e       r_after_done;   // where DONE goes next (IDLE or a drain state)
    bridge_req_t         r_lat;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req;
    logic                r_pready;
    logic                r_pslverr;
    logic [APB_DW-1:0]   r_prdata;
    logic                r_rready;
    logic [OBI_IDW-1:0]  r_aid;

    logic w_setup;
    logic w_timeout;
    logic w_rid_ok;

    assign w_setup   = APB_PSEL && !APB_PENABLE;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_rid_ok  = (obi_rid == OBI_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_after_done <= IDLE;
            r_lat        <= '0;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_prdata     <= '0;
            r_rready     <= 1'b0;
            r_aid        <= OBI_ID;
        end else begin
            r_rready <= 1'b1;
            r_aid    <= OBI_ID;
            case (r_state)
                IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    if (w_setup) begin
                        r_lat.addr  <= APB_PADDR;
                        r_lat.we    <= APB_PWRITE;
                        r_lat.be    <= APB_PWRITE ? APB_PSTRB : '1;
                        r_lat.wdata <= APB_PWRITE ? APB_PWDATA : '0;
                        if (APB_PWRITE && (APB_PSTRB == '0)) begin
                            // Nothing to write: complete locally, OBI untouched.
                            r_state      <= DONE;
                            r_after_done <= IDLE;
                            r_pready     <= 1'b1;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end
                REQ: begin
                    // rvalid cannot belong to this transfer yet and is ignored.
                    if (w_timeout) begin
                        r_state   <= DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        r_prdata  <= '0;
                        // A grant on the timeout edge still commits the OBI
                        // transfer, so only its response remains to be drained.
                        if (obi_gnt) begin
                            r_req        <= 1'b0;
                            r_after_done <= DRAIN_RSP;
                        end else begin
                            r_after_done <= DRAIN_REQ;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (obi_gnt) begin
                            r_req   <= 1'b0;
                            r_state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (obi_rvalid) begin
                        r_state      <= DONE;
                        r_after_done <= IDLE;
                        r_pready     <= 1'b1;
                        if (w_rid_ok) begin
                            r_pslverr <= obi_err;
                            r_prdata  <= (!r_lat.we && !obi_err) ? obi_rdata : '0;
                        end else begin
                            r_pslverr <= 1'b1;
                            r_prdata  <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= DONE;
                        r_after_done <= DRAIN_RSP;
                        r_pready     <= 1'b1;
                        r_pslverr    <= 1'b1;
                        r_prdata     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    // The OBI side keeps moving during the APB completion
                    // cycle, so drain progress is tracked here as well.
                    case (r_after_done)
                        DRAIN_REQ: begin
                            if (obi_gnt) begin
                                r_req   <= 1'b0;
                                r_state <= DRAIN_RSP;
                            end else begin
                                r_state <= DRAIN_REQ;
                            end
                        end
                        DRAIN_RSP: r_state <= obi_rvalid ? IDLE : DRAIN_RSP;
                        default:   r_state <= IDLE;
                    endcase
                end
                DRAIN_REQ: begin
                    if (obi_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= DRAIN_RSP;
                    end
                end
                DRAIN_RSP: begin
                    if (obi_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign APB_PRDATA  = r_prdata;
    assign APB_PREADY  = r_pready;
    assign APB_PSLVERR = r_pslverr;
    assign obi_req     = r_req;
    assign obi_addr    = r_lat.addr;
    assign obi_we      = r_lat.we;
    assign obi_be      = r_lat.be;
    assign obi_wdata   = r_lat.wdata;
    assign obi_aid     = r_aid;
    assign obi_rready  = r_rready;

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_to_obi_bridge
// APB transfers are driven by tasks; a configurable OBI responder grants and
// answers requests; expected APB completions go into a queue and are popped
// and compared whenever PREADY is seen.
// ----------------------------------------------------------------------------
module tb_apb_to_obi_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] APB_PADDR;
    logic        APB_PSEL;
    logic        APB_PENABLE;
    logic        APB_PWRITE;
    logic [31:0] APB_PWDATA;
    logic [3:0]  APB_PSTRB;
    logic [31:0] APB_PRDATA;
    logic        APB_PREADY;
    logic        APB_PSLVERR;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic [0:0]  obi_aid;
    logic        obi_rvalid;
    logic        obi_rready;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic [0:0]  obi_rid;

    apb_to_obi_bridge #(
        .APB_AW         (32),
        .APB_DW         (32),
        .OBI_IDW        (1),
        .OBI_ID         (1'b0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .APB_PADDR   (APB_PADDR),
        .APB_PSEL    (APB_PSEL),
        .APB_PENABLE (APB_PENABLE),
        .APB_PWRITE  (APB_PWRITE),
        .APB_PWDATA  (APB_PWDATA),
        .APB_PSTRB   (APB_PSTRB),
        .APB_PRDATA  (APB_PRDATA),
        .APB_PREADY  (APB_PREADY),
        .APB_PSLVERR (APB_PSLVERR),
        .obi_req     (obi_req),
        .obi_gnt     (obi_gnt),
        .obi_addr    (obi_addr),
        .obi_we      (obi_we),
        .obi_be      (obi_be),
        .obi_wdata   (obi_wdata),
        .obi_aid     (obi_aid),
        .obi_rvalid  (obi_rvalid),
        .obi_rready  (obi_rready),
        .obi_rdata   (obi_rdata),
        .obi_err     (obi_err),
        .obi_rid     (obi_rid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard entry: {pslverr, prdata}
    logic [32:0] sb_q[$];

    // Expected address-phase values of the transfer currently on OBI
    logic [31:0] exp_addr  = '0;
    logic        exp_we    = 1'b0;
    logic [3:0]  exp_be    = '0;
    logic [31:0] exp_wdata = '0;

    // OBI responder configuration
    int          cfg_gnt_delay = 0;
    int          cfg_rsp_delay = 0;
    logic [31:0] cfg_rdata     = '0;
    logic        cfg_err       = 1'b0;
    logic [0:0]  cfg_rid       = 1'b0;
    int          req_cycles    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // OBI responder: grant after cfg_gnt_delay cycles of obi_req, answer
    // cfg_rsp_delay+1 cycles after the grant.
    initial begin
        int gnt_cnt;
        int rsp_cnt;
        gnt_cnt    = 0;
        rsp_cnt    = -1;
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        obi_err    = 1'b0;
        obi_rid    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            obi_gnt    = 1'b0;
            obi_rvalid = 1'b0;
            obi_rdata  = '0;
            obi_err    = 1'b0;
            obi_rid    = 1'b0;
            if (reset) begin
                gnt_cnt = 0;
                rsp_cnt = -1;
            end else begin
                if (rsp_cnt == 0) begin
                    obi_rvalid = 1'b1;
                    obi_rdata  = cfg_rdata;
                    obi_err    = cfg_err;
                    obi_rid    = cfg_rid;
                    rsp_cnt    = -1;
                end else if (rsp_cnt > 0) begin
                    rsp_cnt--;
                end
                if (obi_req) begin
                    if (gnt_cnt >= cfg_gnt_delay) begin
                        obi_gnt = 1'b1;
                        gnt_cnt = 0;
                        rsp_cnt = cfg_rsp_delay;
                    end else begin
                        gnt_cnt++;
                    end
                end
            end
        end
    end

    // Address phase must match the APB request and stay stable while obi_req is high.
    always @(negedge clk) begin
        if (!reset && obi_req) begin
            req_cycles++;
            check_val("obi_addr",  obi_addr,  exp_addr);
            check_val("obi_we",    {31'b0, obi_we}, {31'b0, exp_we});
            check_val("obi_be",    {28'b0, obi_be}, {28'b0, exp_be});
            check_val("obi_wdata", obi_wdata, exp_wdata);
            check_val("obi_rready", {31'b0, obi_rready}, 32'd1);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (APB_PREADY) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_pready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("prdata",  APB_PRDATA, e[31:0]);
                check_val("pslverr", {31'b0, APB_PSLVERR}, {31'b0, e[32]});
            end
        end
    end

    task automatic set_expect(input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] strb);
        exp_addr  = addr;
        exp_we    = we;
        exp_be    = we ? strb : 4'hF;
        exp_wdata = we ? wdata : 32'h0;
    endtask

    // Wait (bounded) for PREADY in access phase, check latency from t0,
    // then finish the APB transfer.
    task automatic finish_xfer(input string name, input int t0, input int exp_lat,
                               output logic req_at_ready);
        int n;
        n = 0;
        while (!APB_PREADY && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({name, "_lat"}, cyc - t0, exp_lat);
        req_at_ready = obi_req;
        @(posedge clk);
        #1;
        check_val({name, "_pready_1cyc"}, {31'b0, APB_PREADY}, 32'd0);
        check_val({name, "_prdata_idle"}, APB_PRDATA, 32'd0);
        APB_PSEL    = 1'b0;
        APB_PENABLE = 1'b0;
        $display("xfer %-12s addr=0x%08h we=%0d latency=%0d", name, APB_PADDR, APB_PWRITE, cyc - t0);
    endtask

    task automatic apb_xfer(input string name, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input int exp_lat, input bit drop_psel,
                            output logic req_at_ready);
        int t0;
        set_expect(addr, we, wdata, strb);
        sb_q.push_back({exp_err, exp_rdata});
        t0          = cyc;
        APB_PADDR   = addr;
        APB_PWRITE  = we;
        APB_PWDATA  = wdata;
        APB_PSTRB   = strb;
        APB_PSEL    = 1'b1;
        APB_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        APB_PENABLE = 1'b1;
        if (drop_psel) APB_PSEL = 1'b0;
        finish_xfer(name, t0, exp_lat, req_at_ready);
    endtask

    task automatic set_cfg(input int gd, input int rd, input logic [31:0] data,
                           input logic err, input logic [0:0] rid);
        cfg_gnt_delay = gd;
        cfg_rsp_delay = rd;
        cfg_rdata     = data;
        cfg_err       = err;
        cfg_rid       = rid;
    endtask

    initial begin
        logic ra;
        int   t0;
        int   rc0;
        int   n;
        reset       = 1'b1;
        APB_PADDR   = '0;
        APB_PSEL    = 1'b0;
        APB_PENABLE = 1'b0;
        APB_PWRITE  = 1'b0;
        APB_PWDATA  = '0;
        APB_PSTRB   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pready",  {31'b0, APB_PREADY},  32'd0);
        check_val("rst_pslverr", {31'b0, APB_PSLVERR}, 32'd0);
        check_val("rst_prdata",  APB_PRDATA, 32'd0);
        check_val("rst_req",     {31'b0, obi_req},    32'd0);
        check_val("rst_addr",    obi_addr, 32'd0);
        check_val("rst_be",      {28'b0, obi_be}, 32'd0);
        check_val("rst_rready",  {31'b0, obi_rready}, 32'd0);
        check_val("rst_aid",     {31'b0, obi_aid},    32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rready_up", {31'b0, obi_rready}, 32'd1);

        // Minimum-latency read
        set_cfg(0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        apb_xfer("rd_fast", 32'h0103_0104, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, ra);

        // Write with grant delayed 5 cycles; read data returned must be ignored
        set_cfg(5, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        apb_xfer("wr_slowgnt", 32'h0103_0200, 1'b1, 32'h12345678, 4'h3, 32'h0, 1'b0, 8, 1'b0, ra);

        // Full-strobe write, fast
        set_cfg(0, 0, 32'h55AA55AA, 1'b0, 1'b0);
        apb_xfer("wr_full", 32'h0000_1000, 1'b1, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0, 3, 1'b0, ra);

        // Error response and ID mismatch
        set_cfg(0, 0, 32'h1111_2222, 1'b1, 1'b0);
        apb_xfer("rd_err", 32'h0000_2004, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b0, ra);
        set_cfg(0, 0, 32'h3333_4444, 1'b0, 1'b1);
        apb_xfer("rd_badid", 32'h0000_2008, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b0, ra);

        // Read with a slower response
        set_cfg(2, 3, 32'h0BAD_F00D, 1'b0, 1'b0);
        apb_xfer("rd_slow", 32'h0000_300C, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 8, 1'b0, ra);

        // Zero-strobe write completes locally without touching OBI
        rc0 = req_cycles;
        apb_xfer("wr_nostrb", 32'h0000_4000, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1, 1'b0, ra);
        check_val("nostrb_no_req", req_cycles - rc0, 32'd0);

        // PSEL dropped after setup: transfer still completes
        set_cfg(1, 0, 32'h7777_8888, 1'b0, 1'b0);
        apb_xfer("rd_psel_drop", 32'h0000_5000, 1'b0, 32'h0, 4'h0, 32'h7777_8888, 1'b0, 4, 1'b1, ra);

        // Timeout with grant withheld; grant at cycle 20, response at 22 is drained
        set_cfg(19, 1, 32'h9999_9999, 1'b0, 1'b0);
        set_expect(32'h0000_6000, 1'b0, 32'h0, 4'h0);
        sb_q.push_back({1'b1, 32'h0});
        t0          = cyc;
        APB_PADDR   = 32'h0000_6000;
        APB_PWRITE  = 1'b0;
        APB_PSEL    = 1'b1;
        APB_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        APB_PENABLE = 1'b1;
        finish_xfer("rd_timeout", t0, 17, ra);
        check_val("timeout_req_held", {31'b0, ra}, 32'd1);
        // Next read: keep presenting a setup phase until the bridge accepts it
        APB_PADDR   = 32'h0000_7000;
        APB_PWRITE  = 1'b0;
        APB_PSEL    = 1'b1;
        APB_PENABLE = 1'b0;
        n = 0;
        while (!(obi_req && obi_addr == 32'h0000_7000) && n < 40) begin
            if (cyc - t0 == 21) set_cfg(0, 0, 32'h600D_CAFE, 1'b0, 1'b0);
            check_val("drain_no_pready", {31'b0, APB_PREADY}, 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_accept_cycle", cyc - t0, 32'd24);
        set_expect(32'h0000_7000, 1'b0, 32'h0, 4'h0);
        sb_q.push_back({1'b0, 32'h600D_CAFE});
        APB_PENABLE = 1'b1;
        finish_xfer("rd_after_drn", t0, 26, ra);

        // Reset during RSP
        set_cfg(0, 10, 32'hBEEF_0001, 1'b0, 1'b0);
        set_expect(32'h0000_8000, 1'b0, 32'h0, 4'h0);
        APB_PADDR   = 32'h0000_8000;
        APB_PWRITE  = 1'b0;
        APB_PSEL    = 1'b1;
        APB_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        APB_PENABLE = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rstrsp_req",     {31'b0, obi_req},    32'd0);
        check_val("rstrsp_pready",  {31'b0, APB_PREADY}, 32'd0);
        check_val("rstrsp_pslverr", {31'b0, APB_PSLVERR}, 32'd0);
        check_val("rstrsp_rready",  {31'b0, obi_rready}, 32'd0);
        APB_PSEL    = 1'b0;
        APB_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_cfg(0, 0, 32'h0123_4567, 1'b0, 1'b0);
        apb_xfer("rd_post_rst", 32'h0000_9000, 1'b0, 32'h0, 4'h0, 32'h0123_4567, 1'b0, 3, 1'b0, ra);

        repeat (5) @(posedge clk);
        #1;
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
